// File: rtl/rpn_stack_ctrl.sv
// RPN stack controller driving an external single-port sync RAM and a combinational ALU.
// Optional macro RPN_STICKY_ERR_EN: the first error locks out PUSH/POP/OPERATE until CLEAR or reset.
module rpn_stack_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_data,
    input  logic [2:0]        cmd_alu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_wren,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [7:0]        alu_out,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W:0]   depth,
    output logic              empty,
    output logic              full
);
    typedef enum logic [3:0] {
        IDLE, PUSH_WR, POP_RD, POP_CAP, OP_RB, OP_RA, OP_CAPA, OP_WR, DONE
    } state_t;

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b11;
    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [ADDR_W:0] SP_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] SP_FULL = (ADDR_W+1)'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W:0]   sp, sp_n;
    logic [ADDR_W-1:0] addr_top, addr_below;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wdata_n, rsp_data_n, a_q, a_n, b_n;
    logic              wren_n, rsp_valid_n;
    logic [1:0]        rsp_err_n, fault;
    logic [2:0]        sel_n;
`ifdef RPN_STICKY_ERR_EN
    logic              sticky, sticky_n;
    logic [1:0]        sticky_err, sticky_err_n;
`endif

    assign addr_top   = sp[ADDR_W-1:0] - ADDR_W'(1);
    assign addr_below = sp[ADDR_W-1:0] - ADDR_W'(2);
    assign cmd_ready  = (state == IDLE);
    assign depth      = sp;
    assign empty      = (sp == '0);
    assign full       = (sp == SP_FULL);
    // Operand A is only readable during OP_CAPA, so present it straight from RAM that cycle.
    assign alu_a      = (state == OP_CAPA) ? mem_rdata : a_q;

    always_comb begin
        state_n     = state;
        sp_n        = sp;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        wren_n      = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        a_n         = a_q;
        b_n         = alu_b;
        sel_n       = alu_sel;
        fault       = ERR_OK;
`ifdef RPN_STICKY_ERR_EN
        sticky_n     = sticky;
        sticky_err_n = sticky_err;
`endif
        case (state)
            IDLE: if (cmd_valid) begin
                if (cmd_op == OP_CLEAR) begin
                    state_n     = DONE;
                    sp_n        = '0;
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_err_n   = ERR_OK;
`ifdef RPN_STICKY_ERR_EN
                    sticky_n    = 1'b0;
`endif
                end
`ifdef RPN_STICKY_ERR_EN
                else if (sticky) begin
                    state_n     = DONE;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = sticky_err;
                end
`endif
                else if (cmd_op == OP_PUSH) begin
                    if (full) fault = ERR_OVF;
                    else begin
                        state_n = PUSH_WR;
                        wren_n  = 1'b1;
                        addr_n  = sp[ADDR_W-1:0];
                        wdata_n = cmd_data;
                    end
                end else if (cmd_op == OP_POP) begin
                    if (empty) fault = ERR_UNF;
                    else begin
                        state_n = POP_RD;
                        addr_n  = addr_top;
                    end
                end else begin
                    if (sp < SP_TWO) fault = ERR_UNF;
                    else begin
                        state_n = OP_RB;
                        addr_n  = addr_top;
                        sel_n   = cmd_alu;
                    end
                end
            end
            PUSH_WR: begin
                state_n     = DONE;
                sp_n        = sp + SP_ONE;
                rsp_valid_n = 1'b1;
                rsp_data_n  = mem_wdata;
                rsp_err_n   = ERR_OK;
            end
            POP_RD:  state_n = POP_CAP;
            POP_CAP: begin
                state_n     = DONE;
                sp_n        = sp - SP_ONE;
                rsp_valid_n = 1'b1;
                rsp_data_n  = mem_rdata;
                rsp_err_n   = ERR_OK;
            end
            OP_RB: begin
                state_n = OP_RA;
                addr_n  = addr_below;
            end
            OP_RA: begin
                state_n = OP_CAPA;
                b_n     = mem_rdata;
            end
            OP_CAPA: begin
                state_n = OP_WR;
                a_n     = mem_rdata;
                wren_n  = 1'b1;
                addr_n  = addr_below;
                wdata_n = alu_out;
            end
            OP_WR: begin
                state_n     = DONE;
                sp_n        = sp - SP_ONE;
                rsp_valid_n = 1'b1;
                rsp_data_n  = mem_wdata;
                rsp_err_n   = ERR_OK;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (fault != ERR_OK) begin
            state_n     = DONE;
            rsp_valid_n = 1'b1;
            rsp_err_n   = fault;
`ifdef RPN_STICKY_ERR_EN
            sticky_n     = 1'b1;
            sticky_err_n = fault;
`endif
        end
    end

    // Reset wins over any pending write because mem_wren is a register cleared here.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            sp        <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= ERR_OK;
            a_q       <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
`ifdef RPN_STICKY_ERR_EN
            sticky     <= 1'b0;
            sticky_err <= ERR_OK;
`endif
        end else begin
            state     <= state_n;
            sp        <= sp_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_wren  <= wren_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            a_q       <= a_n;
            alu_b     <= b_n;
            alu_sel   <= sel_n;
`ifdef RPN_STICKY_ERR_EN
            sticky     <= sticky_n;
            sticky_err <= sticky_err_n;
`endif
        end
    end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl (DEPTH=4) with a behavioural sync RAM and ALU.
module tb_rpn_stack_ctrl;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, OPER = 2'b10, CLR = 2'b11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [7:0]        cmd_data = 8'h00;
    logic [2:0]        cmd_alu = 3'd0;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata, mem_rdata, alu_a, alu_b, alu_out, rsp_data;
    logic              mem_wren, rsp_valid, empty, full;
    logic [2:0]        alu_sel;
    logic [1:0]        rsp_err;
    logic [ADDR_W:0]   depth;

    int errors = 0;
    int checks = 0;

    logic       c_rv [1:6];
    logic       c_we [1:6];
    logic [7:0] c_rd [1:6];
    logic [1:0] c_re [1:6];
    logic [7:0] c_wa [1:6];
    logic [7:0] c_wd [1:6];
    logic [7:0] c_a3, c_b3;
    logic [2:0] c_s3;
    logic [8:0] c_depth;
    logic       c_full, c_empty;
    logic [7:0] ram [0:255];

    rpn_stack_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLOCK_50(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_alu(cmd_alu),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .depth(depth), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always_comb begin
        alu_out = alu_a;
        case (alu_sel)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command, then scramble the inputs and record cycles T+1..T+6.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, input logic [2:0] alu);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_alu = alu;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~data; cmd_alu = ~alu;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            c_rv[k] = rsp_valid; c_rd[k] = rsp_data; c_re[k] = rsp_err;
            c_we[k] = mem_wren;  c_wa[k] = mem_addr; c_wd[k] = mem_wdata;
            if (k == 3) begin c_a3 = alu_a; c_b3 = alu_b; c_s3 = alu_sel; end
        end
        c_depth = depth; c_full = full; c_empty = empty;
    endtask

    task automatic expect_rsp(input string tag, input int lat, input int data, input int err);
        int first, cnt;
        first = 0; cnt = 0;
        for (int k = 1; k <= 6; k++)
            if (c_rv[k]) begin
                cnt++;
                if (first == 0) first = k;
            end
        chk({tag, " rsp_lat"}, first, lat);
        chk({tag, " rsp_pulses"}, cnt, 1);
        chk({tag, " rsp_data"}, {24'd0, c_rd[6]}, data);
        chk({tag, " rsp_err"}, {30'd0, c_re[6]}, err);
    endtask

    task automatic expect_wr(input string tag, input int at, input int addr, input int data);
        int first, cnt;
        first = 0; cnt = 0;
        for (int k = 1; k <= 6; k++)
            if (c_we[k]) begin
                cnt++;
                if (first == 0) first = k;
            end
        chk({tag, " wr_cnt"}, cnt, (at == 0) ? 0 : 1);
        if (at != 0) begin
            chk({tag, " wr_cycle"}, first, at);
            chk({tag, " wr_addr"}, {24'd0, c_wa[first]}, addr);
            chk({tag, " wr_data"}, {24'd0, c_wd[first]}, data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst depth", {23'd0, depth}, 0);
        chk("rst empty/full", {30'd0, empty, full}, 2);
        chk("rst rsp", {21'd0, rsp_valid, rsp_data, rsp_err}, 0);
        chk("rst mem", {15'd0, mem_wren, mem_addr, mem_wdata}, 0);
        chk("rst alu", {13'd0, alu_a, alu_b, alu_sel}, 0);

        // 5 3 + -> 8
        do_cmd(PUSH, 8'd5, 3'd0); expect_rsp("push5", 2, 5, 0); expect_wr("push5", 1, 0, 5);
        chk("push5 depth", c_depth, 1);
        do_cmd(PUSH, 8'd3, 3'd0); expect_rsp("push3", 2, 3, 0); expect_wr("push3", 1, 1, 3);
        do_cmd(OPER, 8'd0, 3'd0); expect_rsp("add", 5, 8, 0); expect_wr("add", 4, 0, 8);
        chk("add depth", c_depth, 1);
        chk("add operands", {11'd0, c_a3, c_b3, c_s3}, {11'd0, 8'd5, 8'd3, 3'd0});

        // push/pop round trip
        do_cmd(PUSH, 8'd7, 3'd0); expect_rsp("push7", 2, 7, 0); expect_wr("push7", 1, 1, 7);
        do_cmd(POP, 8'd0, 3'd0); expect_rsp("pop7", 3, 7, 0); expect_wr("pop7", 0, 0, 0);
        chk("pop7 addr", {24'd0, c_wa[1]}, 1);
        do_cmd(POP, 8'd0, 3'd0); expect_rsp("pop8", 3, 8, 0);
        chk("pop8 empty", {23'd0, c_empty, c_depth}, {23'd0, 1'b1, 9'd0});

        // underflow on empty POP and on OPERATE with one entry
        do_cmd(POP, 8'd0, 3'd0); expect_rsp("pop_empty", 1, 8, 2); expect_wr("pop_empty", 0, 0, 0);
        chk("pop_empty depth", c_depth, 0);
        do_cmd(CLR, 8'd0, 3'd0); expect_rsp("clr1", 1, 0, 0);
        do_cmd(PUSH, 8'd200, 3'd0); expect_rsp("push200", 2, 200, 0);
        do_cmd(OPER, 8'd0, 3'd0); expect_rsp("op_short", 1, 200, 2); expect_wr("op_short", 0, 0, 0);
        chk("op_short depth", c_depth, 1);
        do_cmd(CLR, 8'd0, 3'd0); expect_rsp("clr2", 1, 0, 0); expect_wr("clr2", 0, 0, 0);
        chk("clr2 depth", c_depth, 0);

        // 200 100 + wraps to 44; 3 10 - gives 249 (A is the deeper entry)
        do_cmd(PUSH, 8'd200, 3'd0);
        do_cmd(PUSH, 8'd100, 3'd0);
        do_cmd(OPER, 8'd0, 3'd0); expect_rsp("add_wrap", 5, 44, 0); expect_wr("add_wrap", 4, 0, 44);
        do_cmd(POP, 8'd0, 3'd0); expect_rsp("pop44", 3, 44, 0);
        do_cmd(PUSH, 8'd3, 3'd0);
        do_cmd(PUSH, 8'd10, 3'd0);
        do_cmd(OPER, 8'd0, 3'd1); expect_rsp("sub", 5, 249, 0); expect_wr("sub", 4, 0, 249);
        chk("sub operands", {11'd0, c_a3, c_b3, c_s3}, {11'd0, 8'd3, 8'd10, 3'd1});
        do_cmd(CLR, 8'd0, 3'd0);

        // fill to DEPTH then overflow
        for (int i = 1; i <= 4; i++) begin
            do_cmd(PUSH, 8'(i), 3'd0); expect_rsp("fill", 2, i, 0); expect_wr("fill", 1, i - 1, i);
        end
        chk("fill full", {23'd0, c_full, c_depth}, {23'd0, 1'b1, 9'd4});
        do_cmd(PUSH, 8'd9, 3'd0); expect_rsp("ovf", 1, 4, 1); expect_wr("ovf", 0, 0, 0);
        chk("ovf full", {23'd0, c_full, c_depth}, {23'd0, 1'b1, 9'd4});
        chk("ovf ram3", {24'd0, ram[3]}, 4);
        do_cmd(CLR, 8'd0, 3'd0); expect_rsp("clr3", 1, 0, 0);
        chk("clr3 full", {23'd0, c_full, c_depth}, 0);

        // reset while OPERATE sits in OP_RA
        do_cmd(PUSH, 8'd5, 3'd0);
        do_cmd(PUSH, 8'd3, 3'd0);
        @(negedge clk); cmd_valid = 1'b1; cmd_op = OPER; cmd_alu = 3'd0;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("abort ready", {31'd0, cmd_ready}, 1);
        chk("abort depth", {23'd0, depth}, 0);
        chk("abort wren/rsp", {30'd0, mem_wren, rsp_valid}, 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || mem_wren) seen = 1'b1;
        end
        chk("abort quiet", {31'd0, seen}, 0);

        // error stickiness
        do_cmd(POP, 8'd0, 3'd0); expect_rsp("st_pop", 1, 0, 2);
        do_cmd(PUSH, 8'd2, 3'd0);
`ifdef RPN_STICKY_ERR_EN
        expect_rsp("st_push", 1, 0, 2); expect_wr("st_push", 0, 0, 0);
        chk("st_push depth", c_depth, 0);
`else
        expect_rsp("st_push", 2, 2, 0); expect_wr("st_push", 1, 0, 2);
        chk("st_push depth", c_depth, 1);
`endif
        do_cmd(CLR, 8'd0, 3'd0); expect_rsp("st_clr", 1, 0, 0);
        do_cmd(PUSH, 8'd2, 3'd0); expect_rsp("st_push2", 2, 2, 0); expect_wr("st_push2", 1, 0, 2);
        chk("st_push2 depth", c_depth, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rpn_stack_ctrl.md
RPN_STACK_CTRL -- requirements
Module: rpn_stack_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, stack RAM address width.
REQ-002 SHALL have parameter DEPTH, default 256, max entries; legal range 2..2**ADDR_W.
REQ-003 SHALL have port CLOCK_50, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have cmd_valid in 1, cmd_ready out 1: command handshake; transfer on a cycle with both high.
REQ-006 SHALL have cmd_op in 2: 00 PUSH, 01 POP, 10 OPERATE, 11 CLEAR.
REQ-007 SHALL have cmd_data in 8 (PUSH value) and cmd_alu in 3 (OPERATE ALU select).
REQ-008 SHALL have mem_addr out ADDR_W, mem_wdata out 8, mem_wren out 1, and mem_rdata in 8: single-port sync RAM; rdata valid 1 cycle after address with mem_wren=0.
REQ-009 SHALL have alu_a out 8, alu_b out 8, alu_sel out 3, and alu_out in 8: combinational ALU.
REQ-010 SHALL have rsp_valid out 1, rsp_data out 8, rsp_err out 2 (00 ok, 01 overflow, 10 underflow): response.
REQ-011 SHALL have depth out ADDR_W+1, empty out 1, full out 1: stack status.

Function
REQ-012 SHALL keep stack pointer sp = entry count; top of stack at address sp-1; empty = (sp==0); full = (sp==DEPTH); depth = sp.
REQ-013 SHALL assert cmd_ready only in IDLE; the requester holds cmd_valid/op/data until accepted; commands are ignored while busy.
REQ-014 SHALL latch cmd_op, cmd_data, and cmd_alu on acceptance (cycle T); later input changes SHALL have no effect on that command.
REQ-015 PUSH, not full: mem_wren=1, mem_addr=sp, mem_wdata=data at T+1; sp+1; rsp_valid at T+2 with rsp_data=data.
REQ-016 POP, not empty: mem_addr=sp-1 at T+1; capture mem_rdata at T+2; sp-1; rsp_valid at T+3 with rsp_data=popped value.
REQ-017 OPERATE, sp>=2: T+1 addr=sp-1; T+2 latch B, addr=sp-2; T+3 latch A; T+4 mem_wren=1, addr=sp-2, wdata=alu_out; sp-1; rsp_valid at T+5 with rsp_data=result.
REQ-018 SHALL drive alu_sel=latched cmd_alu, and alu_a/alu_b from the A/B latches, stable from T+3 until next OPERATE.
REQ-019 CLEAR: sp=0, no memory access, rsp_valid at T+1 with rsp_err=00 and rsp_data=0.
REQ-020 PUSH when full: no write, sp unchanged, rsp_valid at T+1 with rsp_err=01.
REQ-021 POP when empty, or OPERATE when sp<2: no write, sp unchanged, rsp_valid at T+1 with rsp_err=10.
REQ-022 rsp_valid SHALL be a one-cycle pulse with no backpressure; rsp_data/rsp_err hold until next response.
REQ-023 mem_wren SHALL be high only in the single PUSH/OPERATE write cycle.
REQ-024 FSM states: IDLE, PUSH_WR, POP_RD, POP_CAP, OP_RB, OP_RA, OP_CAPA, OP_WR, DONE; every non-IDLE path SHALL end in DONE then IDLE.
REQ-025 The ALU result SHALL be written truncated to 8 bits, with no overflow flag from this block.

Reset
REQ-026 On reset: state=IDLE, sp=0, mem_wren=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=00, alu_a=alu_b=0, alu_sel=0, cmd_ready=1 the following cycle.
REQ-027 Reset mid-command SHALL abort it: no response, and any pending write suppressed on the same edge.

Configuration
REQ-028 Macro RPN_STICKY_ERR_EN SHALL control error latching.
REQ-029 With RPN_STICKY_ERR_EN defined: the first error sets a sticky flag; until CLEAR or reset, PUSH/POP/OPERATE SHALL make no state or memory change and respond at T+1 with the original error code.
REQ-030 Without RPN_STICKY_ERR_EN: errors are reported per-response only and do not affect later commands.

Verification
REQ-031 Reset; PUSH 5, PUSH 3, OPERATE sel=add -> write 8 at addr 0 at T+4; rsp_data=8 at T+5; depth=1.
REQ-032 PUSH 7, POP -> rsp_data=7 at T+3, rsp_err=00, empty=1.
REQ-033 Empty stack, POP -> rsp_err=10 at T+1, mem_wren never high, depth=0; same for OPERATE with depth=1.
REQ-034 DEPTH=4; push 1,2,3,4 then PUSH 9 -> rsp_err=01, full=1, addr 3 still holds 4.
REQ-035 Assert reset at OP_RA of an OPERATE -> no rsp_valid, mem_wren=0, depth=0, cmd_ready=1 next cycle.
REQ-036 With RPN_STICKY_ERR_EN: POP on empty, then PUSH 2 -> rsp_err=10, depth=0; CLEAR, then PUSH 2 -> rsp_err=00, depth=1.
